// File: rtl/tictactoe_pkg.sv
// Shared definitions for the tic-tac-toe game controller.
//   - cell codes (also used for player and winner encodings)
//   - FSM state type
//   - table of the 8 winning lines as 0-based cell index triples
//   - helpers to read and write one 2-bit cell of the packed 18-bit board
package tictactoe_pkg;

    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] P1    = 2'b01;
    localparam logic [1:0] P2    = 2'b10;
    localparam logic [1:0] TIE   = 2'b11;

    localparam int unsigned NUM_CELLS = 9;
    localparam int unsigned NUM_LINES = 8;
    localparam int unsigned MIN_POS   = 1;
    localparam int unsigned MAX_POS   = 9;

    typedef enum logic [1:0] {IDLE, TURN, CHECK, GAME_OVER} state_e;

    // Rows, columns, then the two diagonals; indices are 0-based (cell 1 -> 0).
    localparam int unsigned WIN_LINES [NUM_LINES][3] = '{
        '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
        '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
        '{0, 4, 8}, '{2, 4, 6}
    };

    // Cell idx (0-based) lives in bits [2*idx+1:2*idx].
    function automatic logic [1:0] get_cell(input logic [17:0] b, input int unsigned idx);
        logic [17:0] shifted;
        shifted = b >> (2 * idx);
        return shifted[1:0];
    endfunction

    function automatic logic [17:0] set_cell(input logic [17:0] b, input int unsigned idx,
                                             input logic [1:0] v);
        logic [17:0] mask;
        mask = 18'(2'b11) << (2 * idx);
        return (b & ~mask) | (18'(v) << (2 * idx));
    endfunction

endpackage

// File: rtl/tictactoe_game_controller_if.sv
// Move handshake between the input/debounce logic and the game controller.
//   move_valid : a move is offered on move_pos
//   move_pos   : target cell 1..9, row-major
//   move_ready : controller can accept a move this cycle
// master = move source, slave = game controller.
interface tictactoe_game_controller_if;

    logic       move_valid;
    logic [3:0] move_pos;
    logic       move_ready;

    modport master (
        output move_valid,
        output move_pos,
        input  move_ready
    );

    modport slave (
        input  move_valid,
        input  move_pos,
        output move_ready
    );

endinterface

// File: rtl/board_line_check.sv
// Combinational line checker.
//   board  : packed 3x3 board, 2 bits per cell
//   player : player code to test for a completed line
//   win    : player owns all three cells of at least one of the 8 lines
//   full   : no empty cell remains
module board_line_check
    import tictactoe_pkg::*;
(
    input  logic [17:0] board,
    input  logic [1:0]  player,
    output logic        win,
    output logic        full
);

    always_comb begin
        win  = 1'b0;
        full = 1'b1;
        for (int unsigned l = 0; l < NUM_LINES; l++) begin
            if (player != EMPTY &&
                get_cell(board, WIN_LINES[l][0]) == player &&
                get_cell(board, WIN_LINES[l][1]) == player &&
                get_cell(board, WIN_LINES[l][2]) == player) begin
                win = 1'b1;
            end
        end
        for (int unsigned c = 0; c < NUM_CELLS; c++) begin
            if (get_cell(board, c) == EMPTY) begin
                full = 1'b0;
            end
        end
    end

endmodule

// File: rtl/tictactoe_game_controller.sv
// Two-player tic-tac-toe sequencer: owns the board, the turn FSM and the per-turn timer.
//   clock, reset_n : clock and asynchronous active-low reset
//   start          : begins a new game from IDLE or GAME_OVER
//   move_bus       : move handshake (valid/pos in, ready out)
//   board          : cell k in bits [2k-1:2k-2]; 00 empty, 01 P1, 10 P2
//   current_player : player to move during TURN/CHECK, 00 otherwise
//   winner         : 00 none, 01 P1, 10 P2, 11 tie
//   game_over      : high in GAME_OVER
//   move_error     : one-cycle pulse on a rejected move
//   timeout        : one-cycle pulse on turn expiry
module tictactoe_game_controller
    import tictactoe_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 250000000
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        start,
    tictactoe_game_controller_if.slave  move_bus,
    output logic [17:0]                 board,
    output logic [1:0]                  current_player,
    output logic [1:0]                  winner,
    output logic                        game_over,
    output logic                        move_error,
    output logic                        timeout
);

    localparam int unsigned   TW         = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

    state_e        state_q, state_d;
    logic [17:0]   board_q, board_d;
    logic [1:0]    player_q, player_d;
    logic [1:0]    winner_q, winner_d;
    logic [TW-1:0] timer_q, timer_d;

    logic          ready;
    logic          line_win, board_full;
    logic          target_empty, free_found, legal;
    int unsigned   pos, free_idx;

    // Only meaningful in CHECK, where board_q already holds the just-placed mark.
    board_line_check u_line_check (
        .board  (board_q),
        .player (player_q),
        .win    (line_win),
        .full   (board_full)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            board_q  <= '0;
            player_q <= EMPTY;
            winner_q <= EMPTY;
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            board_q  <= board_d;
            player_q <= player_d;
            winner_q <= winner_d;
            timer_q  <= timer_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        board_d      = board_q;
        player_d     = player_q;
        winner_d     = winner_q;
        timer_d      = timer_q;
        ready        = 1'b0;
        move_error   = 1'b0;
        timeout      = 1'b0;
        pos          = {28'd0, move_bus.move_pos};
        target_empty = 1'b0;
        free_found   = 1'b0;
        free_idx     = 0;

        // Occupancy of the offered cell, and the lowest empty cell for auto-placement.
        for (int unsigned c = 0; c < NUM_CELLS; c++) begin
            if (c + 1 == pos) begin
                target_empty = (get_cell(board_q, c) == EMPTY);
            end
            if (!free_found && get_cell(board_q, c) == EMPTY) begin
                free_found = 1'b1;
                free_idx   = c;
            end
        end
        legal = (pos >= MIN_POS) && (pos <= MAX_POS) && target_empty;

        unique case (state_q)
            IDLE, GAME_OVER: begin
                if (start) begin
                    board_d  = '0;
                    winner_d = EMPTY;
                    player_d = P1;
                    timer_d  = '0;
                    state_d  = TURN;
                end
            end
            TURN: begin
                ready   = 1'b1;
                timer_d = timer_q + TIMER_ONE;
                if (move_bus.move_valid && legal) begin
                    // A legal move on the expiry cycle beats the timeout.
                    board_d = set_cell(board_q, pos - 1, player_q);
                    state_d = CHECK;
                end else begin
                    move_error = move_bus.move_valid;
                    if (timer_q == TIMER_LAST) begin
                        timeout = 1'b1;
                        board_d = set_cell(board_q, free_idx, player_q);
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                if (line_win) begin
                    winner_d = player_q;
                    player_d = EMPTY;
                    state_d  = GAME_OVER;
                end else if (board_full) begin
                    winner_d = TIE;
                    player_d = EMPTY;
                    state_d  = GAME_OVER;
                end else begin
                    player_d = (player_q == P1) ? P2 : P1;
                    timer_d  = '0;
                    state_d  = TURN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign move_bus.move_ready = ready;
    assign board               = board_q;
    assign current_player      = player_q;
    assign winner              = winner_q;
    assign game_over           = (state_q == GAME_OVER);

endmodule

// File: tb/tb_tictactoe_game_controller.sv
// Scoreboard bench for tictactoe_game_controller (TIMEOUT_CYCLES = 8).
// Stimulus drives one cycle at a time just after the rising edge and queues the outputs
// expected for that cycle; the monitor samples on the falling edge and pops/compares.
module tb_tictactoe_game_controller;

    typedef struct {
        string       name;
        logic [17:0] board;
        logic [1:0]  player;
        logic [1:0]  winner;
        logic        go;
        logic        ready;
        logic        err;
        logic        to;
    } exp_t;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic [17:0] board;
    logic [1:0]  current_player;
    logic [1:0]  winner;
    logic        game_over;
    logic        move_error;
    logic        timeout;

    tictactoe_game_controller_if mif ();

    tictactoe_game_controller #(
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .start          (start),
        .move_bus       (mif),
        .board          (board),
        .current_player (current_player),
        .winner         (winner),
        .game_over      (game_over),
        .move_error     (move_error),
        .timeout        (timeout)
    );

    exp_t        q[$];
    int          total = 0;
    int          bad = 0;
    bit          stim_done = 0;
    logic [17:0] exp_board;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got=running want=finished");
        $fatal(1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic push(input string n, input logic [17:0] b, input logic [1:0] p,
                        input logic [1:0] w, input logic go, input logic rdy,
                        input logic err, input logic to);
        exp_t e;
        e.name = n; e.board = b; e.player = p; e.winner = w;
        e.go = go; e.ready = rdy; e.err = err; e.to = to;
        q.push_back(e);
    endtask

    task automatic cyc(input logic st, input logic v, input logic [3:0] p);
        @(posedge clock);
        #1;
        start          = st;
        mif.move_valid = v;
        mif.move_pos   = p;
    endtask

    // One accepted move: offer cycle (TURN), then CHECK cycle, then GAME_OVER if it ends.
    task automatic play(input string n, input logic [3:0] p, input logic [1:0] mover,
                        input logic [17:0] b_after, input logic [1:0] w_after);
        cyc(1'b0, 1'b1, p);
        push({n, "_offer"}, exp_board, mover, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 4'd0);
        push({n, "_check"}, b_after, mover, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_board = b_after;
        if (w_after != 2'b00) begin
            cyc(1'b0, 1'b0, 4'd0);
            push({n, "_over"}, b_after, 2'b00, w_after, 1'b1, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic bad_move(input string n, input logic [3:0] p, input logic [1:0] pl);
        cyc(1'b0, 1'b1, p);
        push(n, exp_board, pl, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic wait_turn(input string n, input int cycles, input logic [1:0] pl);
        for (int i = 0; i < cycles; i++) begin
            cyc(1'b0, 1'b0, 4'd0);
            push(n, exp_board, pl, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset_n        = 1'b1;
        start          = 1'b0;
        mif.move_valid = 1'b0;
        mif.move_pos   = 4'd0;
        exp_board      = '0;
        #1 reset_n = 1'b0;

        @(posedge clock); #1;
        push("reset", '0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        push("reset_release", '0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Row win for P1.
        cyc(1'b1, 1'b0, 4'd0);
        push("t1_idle_start", '0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        play("t1_m1", 4'd1, 2'b01, 18'b00_00_00_00_00_00_00_00_01, 2'b00);
        play("t1_m4", 4'd4, 2'b10, 18'b00_00_00_00_00_10_00_00_01, 2'b00);
        play("t1_m2", 4'd2, 2'b01, 18'b00_00_00_00_00_10_00_01_01, 2'b00);
        play("t1_m5", 4'd5, 2'b10, 18'b00_00_00_00_10_10_00_01_01, 2'b00);
        play("t1_m3", 4'd3, 2'b01, 18'b00_00_00_00_10_10_01_01_01, 2'b01);
        cyc(1'b0, 1'b1, 4'd6);
        push("go_ignore_move", exp_board, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 4'd0);
        push("go_start", exp_board, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_board = '0;

        // Full board, no line: tie.
        play("t4_m1", 4'd1, 2'b01, 18'b00_00_00_00_00_00_00_00_01, 2'b00);
        play("t4_m2", 4'd2, 2'b10, 18'b00_00_00_00_00_00_00_10_01, 2'b00);
        play("t4_m3", 4'd3, 2'b01, 18'b00_00_00_00_00_00_01_10_01, 2'b00);
        play("t4_m5", 4'd5, 2'b10, 18'b00_00_00_00_10_00_01_10_01, 2'b00);
        play("t4_m4", 4'd4, 2'b01, 18'b00_00_00_00_10_01_01_10_01, 2'b00);
        play("t4_m6", 4'd6, 2'b10, 18'b00_00_00_10_10_01_01_10_01, 2'b00);
        play("t4_m8", 4'd8, 2'b01, 18'b00_01_00_10_10_01_01_10_01, 2'b00);
        play("t4_m7", 4'd7, 2'b10, 18'b00_01_10_10_10_01_01_10_01, 2'b00);
        play("t4_m9", 4'd9, 2'b01, 18'b01_01_10_10_10_01_01_10_01, 2'b11);
        cyc(1'b1, 1'b0, 4'd0);
        push("go_start2", exp_board, 2'b00, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_board = '0;

        // Rejected moves: occupied cell, pos 0, pos 10.
        play("t2_p1_5", 4'd5, 2'b01, 18'b00_00_00_00_01_00_00_00_00, 2'b00);
        bad_move("t2_occupied", 4'd5, 2'b10);
        wait_turn("t2_err_clear", 1, 2'b10);
        bad_move("t3_pos0", 4'd0, 2'b10);
        bad_move("t3_pos10", 4'd10, 2'b10);
        wait_turn("t3_err_clear", 1, 2'b10);
        play("t2_p2_6", 4'd6, 2'b10, 18'b00_00_00_10_01_00_00_00_00, 2'b00);
        cyc(1'b1, 1'b0, 4'd0);
        push("start_in_turn", exp_board, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_turn("start_ignored", 1, 2'b01);

        // Asynchronous reset, asserted away from any rising edge.
        @(posedge clock); #2;
        reset_n        = 1'b0;
        start          = 1'b0;
        mif.move_valid = 1'b0;
        push("t6_async_reset", '0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clock); #1;
        push("t6_reset_held", '0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        push("t6_reset_release", '0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_board = '0;

        // Turn expiry with auto-placement.
        cyc(1'b1, 1'b0, 4'd0);
        push("t5_start", '0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_turn("t5_wait1", 7, 2'b01);
        cyc(1'b0, 1'b0, 4'd0);
        push("t5_expire1", exp_board, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 4'd0);
        exp_board = 18'b00_00_00_00_00_00_00_00_01;
        push("t5_auto1", exp_board, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        wait_turn("t5_wait2", 7, 2'b10);
        cyc(1'b0, 1'b1, 4'd1);
        push("t5_err_and_expire", exp_board, 2'b10, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 4'd0);
        exp_board = 18'b00_00_00_00_00_00_00_10_01;
        push("t5_auto2", exp_board, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        wait_turn("t5_wait3", 7, 2'b01);
        cyc(1'b0, 1'b1, 4'd9);
        push("t5_move_beats_expire", exp_board, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 4'd0);
        exp_board = 18'b01_00_00_00_00_00_00_10_01;
        push("t5_move9", exp_board, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_turn("t5_next_turn", 1, 2'b10);

        stim_done = 1'b1;
    end

    // ---------------- monitor / scoreboard ----------------
    task automatic chk(input string n, input string f, input logic [17:0] act,
                       input logic [17:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s.%s got=%0h want=%0h", n, f, act, want);
        end
    endtask

    initial begin : monitor
        exp_t e;
        do begin
            @(negedge clock);
            if (q.size() == 0) begin
                total++;
                if (move_error || timeout) begin
                    bad++;
                    $display("FAIL spurious_pulse got=%0b%0b want=00", move_error, timeout);
                end
            end
            while (q.size() != 0) begin
                e = q.pop_front();
                chk(e.name, "board", board, e.board);
                chk(e.name, "current_player", 18'(current_player), 18'(e.player));
                chk(e.name, "winner", 18'(winner), 18'(e.winner));
                chk(e.name, "game_over", 18'(game_over), 18'(e.go));
                chk(e.name, "move_ready", 18'(mif.move_ready), 18'(e.ready));
                chk(e.name, "move_error", 18'(move_error), 18'(e.err));
                chk(e.name, "timeout", 18'(timeout), 18'(e.to));
            end
        end while (!stim_done);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain got=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tictactoe_game_controller.md
Name: tictactoe_game_controller

Overview:
Sequences a two-player tic-tac-toe game on a 3x3 board. Owns the board register and the turn state machine, and arbitrates one shared move input between player 1 and player 2. Enforces a per-turn timeout and detects win or tie through an internal line checker. Sits between the input/debounce logic and the display/VGA renderer of the game.

Parameters:
TIMEOUT_CYCLES, 250000000, clock cycles allowed per turn (5 s at 50 MHz); minimum 2; counter width is $clog2(TIMEOUT_CYCLES).

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
start  input  1  level; begins a new game from IDLE or GAME_OVER
move_valid  input  1  a move is offered on move_pos
move_pos  input  4  target cell, 1..9, row-major (1 = top-left)
move_ready  output  1  controller can accept a move this cycle
board  output  18  cell k occupies bits [2k-1:2k-2]; 00 empty, 01 P1, 10 P2
current_player  output  2  01 or 10 during a turn; 00 otherwise
winner  output  2  00 none, 01 P1, 10 P2, 11 tie
game_over  output  1  high while in GAME_OVER
move_error  output  1  one-cycle pulse on a rejected move
timeout  output  1  one-cycle pulse on a turn expiry

Behaviour:
- One clock domain. Reset is asynchronous and active-low: clock and reset_n, with polarity and synchronicity fixed.
- Reset values: state IDLE, board 0, current_player 00, winner 00, game_over 0, move_ready 0, move_error 0, timeout 0, turn timer 0.
- States: IDLE, TURN, CHECK, GAME_OVER.
- IDLE: move_ready 0. When start=1, at the next edge the board clears, current_player becomes 01, the timer resets to 0, and the state goes to TURN.
- TURN: move_ready 1. A move is accepted on a cycle with move_valid && move_ready.
  - Legal move (move_pos in 1..9 and the cell is 00): the cell is written with current_player at that edge, and the state goes to CHECK.
  - Illegal move (pos 0 or 10..15, or the cell is occupied): move_error pulses for 1 cycle. State, board and player are unchanged; the timer keeps running.
- Turn timer: increments on every TURN cycle. On the cycle the timer equals TIMEOUT_CYCLES-1 with no legal move accepted:
  - timeout pulses for 1 cycle;
  - current_player is auto-placed in the lowest-index empty cell;
  - the state goes to CHECK.
  - TURN always has at least one empty cell, so auto-placement always succeeds.
- Simultaneous legal move and expiry: the player's move wins; no timeout pulse.
- Simultaneous illegal move and expiry: move_error and timeout both pulse, and the auto-placement proceeds.
- CHECK: 1 cycle, move_ready 0. Evaluates the 8 lines (3 rows, 3 columns, 2 diagonals) on the updated board for the player who just moved.
  - Win: winner = that player, state goes to GAME_OVER.
  - Otherwise, all 9 cells occupied: winner = 11, state goes to GAME_OVER.
  - Otherwise: current_player toggles (01 and 10), the timer resets to 0, and the state goes to TURN.
- Latency: accepted move to board update is 1 edge; to winner/game_over or the player switch is 2 edges.
- GAME_OVER: game_over 1, move_ready 0, current_player 00, board and winner held. move_valid is ignored (no error). start=1 clears the board and winner and enters TURN with P1; P1 always opens.
- start is ignored in TURN and CHECK.
- move_error and timeout are never asserted outside TURN.
- reset_n low mid-game returns all outputs to reset values immediately (asynchronously).

Decomposition:
- Package tictactoe_pkg:
  - cell codes EMPTY=2'b00, P1=2'b01, P2=2'b10, TIE=2'b11;
  - state enum {IDLE, TURN, CHECK, GAME_OVER};
  - constant table of the 8 winning lines as cell index triples;
  - localparams NUM_CELLS=9, MIN_POS=1, MAX_POS=9.
- Sub-module board_line_check: purely combinational; inputs board[17:0] and player[1:0]; outputs win and full. Instanced once, evaluated in CHECK.

Test Plan:
1. Run with TIMEOUT_CYCLES=8. Reset, start; moves 1, 4, 2, 5, 3 -> board cells 1,2,3=01 and 4,5=10; winner=01 and game_over=1 two edges after the move to 3 is accepted; move_ready=0 afterwards.
2. P1 plays 5, then P2 offers 5 -> move_error high exactly 1 cycle; board unchanged; current_player stays 10; a following P2 move to 6 is accepted.
3. move_pos=0 and then move_pos=10 in TURN -> move_error pulse each time; no state or board change.
4. Moves 1,2,3,5,4,6,8,7,9 -> no intermediate win; after the move to 9, winner=11 and game_over=1.
5. TIMEOUT_CYCLES=8, start, no moves -> after 8 TURN cycles, timeout pulses once and cell 1=01; then current_player=10. Eight more idle cycles -> cell 2=10.
6. Mid-game reset_n low -> board=0, state IDLE, all outputs at reset values without waiting for a clock edge. Separately, start in GAME_OVER -> board cleared, winner=00, current_player=01.
